// File: rtl/sdram_port_arb.sv
// Three-port arbiter for the SDRAM command port: one transaction at a time, fixed priority 0>1>2
// with a starvation override for port 2. Grant 1 cycle after request; requesters hold req until ack.
module sdram_port_arb #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_be,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_be,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic              p2_req,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [DATA_W-1:0] p2_wdata,
    input  logic [1:0]        p2_be,
    output logic              p2_ack,
    output logic [DATA_W-1:0] p2_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic              busy
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                    state, state_nxt;
    logic [2:0]                req_v, we_v;
    logic [2:0][ADDR_W-1:0]    addr_v;
    logic [2:0][DATA_W-1:0]    wdata_v;
    logic [2:0][1:0]           be_v;
    logic [1:0]                win;
    logic [CNT_W-1:0]          starve_cnt, starve_nxt;
    logic                      mem_req_nxt, mem_we_nxt, busy_nxt;
    logic [ADDR_W-1:0]         mem_addr_nxt;
    logic [DATA_W-1:0]         mem_wdata_nxt;
    logic [1:0]                mem_be_nxt, grant_nxt;
    logic [2:0]                ack_q, ack_nxt;
    logic [2:0][DATA_W-1:0]    rdata_q, rdata_nxt;

    assign req_v   = {p2_req, p1_req, p0_req};
    assign we_v    = {p2_we, p1_we, p0_we};
    assign addr_v  = {p2_addr, p1_addr, p0_addr};
    assign wdata_v = {p2_wdata, p1_wdata, p0_wdata};
    assign be_v    = {p2_be, p1_be, p0_be};

    assign p0_ack   = ack_q[0];
    assign p1_ack   = ack_q[1];
    assign p2_ack   = ack_q[2];
    assign p0_rdata = rdata_q[0];
    assign p1_rdata = rdata_q[1];
    assign p2_rdata = rdata_q[2];

    // A starved port 2 overrides the fixed order once it has lost STARVE_MAX times in a row.
    always_comb begin
        win = 2'd2;
        if (req_v[2] && starve_cnt == CNT_MAX) win = 2'd2;
        else if (req_v[0])                     win = 2'd0;
        else if (req_v[1])                     win = 2'd1;
    end

    always_comb begin
        state_nxt     = state;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_be_nxt    = mem_be;
        grant_nxt     = grant;
        busy_nxt      = busy;
        starve_nxt    = starve_cnt;
        ack_nxt       = '0;
        rdata_nxt     = rdata_q;
        case (state)
            IDLE: begin
                if (|req_v) begin
                    state_nxt     = BUSY;
                    mem_req_nxt   = 1'b1;
                    busy_nxt      = 1'b1;
                    grant_nxt     = win;
                    mem_we_nxt    = we_v[win];
                    mem_addr_nxt  = addr_v[win];
                    mem_wdata_nxt = wdata_v[win];
                    mem_be_nxt    = be_v[win];
                    if (win == 2'd2 || !req_v[2]) starve_nxt = '0;
                    else if (starve_cnt != CNT_MAX) starve_nxt = starve_cnt + CNT_W'(1);
                end
            end
            BUSY: begin
                // Requester inputs are not looked at here; mem_* hold their latched values.
                if (mem_ack) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    busy_nxt    = 1'b0;
                    grant_nxt   = 2'd3;
                    for (int i = 0; i < 3; i++) begin
                        if (grant == 2'(i)) begin
                            ack_nxt[i]   = 1'b1;
                            rdata_nxt[i] = mem_rdata;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            grant      <= 2'd3;
            busy       <= 1'b0;
            starve_cnt <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state      <= state_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            mem_be     <= mem_be_nxt;
            grant      <= grant_nxt;
            busy       <= busy_nxt;
            starve_cnt <= starve_nxt;
            ack_q      <= ack_nxt;
            rdata_q    <= rdata_nxt;
        end
    end
endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: directed scenarios plus randomized traffic, all checked each cycle
// against a transaction-level reference model and a simple latency-programmable controller.
module tb_sdram_port_arb;
    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int STARVE_MAX = 8;

    logic              clk_sys = 1'b0;
    logic              reset = 1'b1;
    logic [2:0]        r_req = '0;
    logic [2:0]        r_we = '0;
    logic [ADDR_W-1:0] r_addr [3];
    logic [DATA_W-1:0] r_wdata [3];
    logic [1:0]        r_be [3];
    logic [2:0]        d_ack;
    logic [DATA_W-1:0] d_rdata [3];
    logic              mem_req, mem_we, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_be, grant;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;

    // controller model knobs
    int                fix_lat = 3;
    bit                rand_lat = 1'b0;
    bit                fix_data_en = 1'b0;
    logic [DATA_W-1:0] fix_rdata = '0;
    int                inject_req = 0, inject_done = 0, lat_cnt = 0, cur_lat = 1;

    // reference model state
    int                m_busy = 0, m_owner = 3, m_cnt = 0;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [1:0]        m_be;
    logic [2:0]        m_ack = '0;
    logic [DATA_W-1:0] m_rdata [3];
    int                grant_log[$];
    int                exp_q[$];

    // requester model
    bit                auto_mode = 1'b0, gap_mode = 1'b0;
    int                remaining[3];
    int                n_cmp = 0, n_fail = 0;

    always #5 clk_sys = ~clk_sys;

    sdram_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .p0_req(r_req[0]), .p0_we(r_we[0]), .p0_addr(r_addr[0]), .p0_wdata(r_wdata[0]),
        .p0_be(r_be[0]), .p0_ack(d_ack[0]), .p0_rdata(d_rdata[0]),
        .p1_req(r_req[1]), .p1_we(r_we[1]), .p1_addr(r_addr[1]), .p1_wdata(r_wdata[1]),
        .p1_be(r_be[1]), .p1_ack(d_ack[1]), .p1_rdata(d_rdata[1]),
        .p2_req(r_req[2]), .p2_we(r_we[2]), .p2_addr(r_addr[2]), .p2_wdata(r_wdata[2]),
        .p2_be(r_be[2]), .p2_ack(d_ack[2]), .p2_rdata(d_rdata[2]),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .grant(grant), .busy(busy)
    );

    // SDRAM controller stand-in: acks cur_lat cycles after mem_req rises, or on an injected pulse.
    always @(negedge clk_sys) begin
        mem_ack = 1'b0;
        if (reset) begin
            lat_cnt = 0;
        end else if (inject_req != inject_done) begin
            inject_done = inject_req;
            mem_ack = 1'b1;
            mem_rdata = 16'hDEAD;
        end else if (mem_req) begin
            if (lat_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : fix_lat;
            lat_cnt++;
            if (lat_cnt >= cur_lat) begin
                mem_ack = 1'b1;
                mem_rdata = fix_data_en ? fix_rdata : DATA_W'($urandom);
                lat_cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 3; m_cnt = 0; m_ack = '0;
        for (int p = 0; p < 3; p++) m_rdata[p] = '0;
    endtask

    function automatic int rem_sum();
        return remaining[0] + remaining[1] + remaining[2];
    endfunction

    task automatic new_params(input int p);
        r_we[p]    = 1'($urandom);
        r_addr[p]  = ADDR_W'($urandom);
        r_wdata[p] = DATA_W'($urandom);
        r_be[p]    = 2'($urandom);
    endtask

    // One clock: advance the model on what the DUT saw at this edge, compare, then drive requesters.
    task automatic tick();
        int w;
        @(posedge clk_sys);
        #1;
        m_ack = '0;
        if (reset) begin
            model_reset();
        end else if (m_busy == 0) begin
            if (|r_req) begin
                if (r_req[2] && m_cnt >= STARVE_MAX) w = 2;
                else if (r_req[0]) w = 0;
                else if (r_req[1]) w = 1;
                else w = 2;
                if (w == 2 || !r_req[2]) m_cnt = 0;
                else if (m_cnt < STARVE_MAX) m_cnt++;
                m_busy = 1; m_owner = w;
                m_we = r_we[w]; m_addr = r_addr[w]; m_wdata = r_wdata[w]; m_be = r_be[w];
                grant_log.push_back(w);
            end
        end else if (mem_ack) begin
            m_ack[m_owner] = 1'b1;
            m_rdata[m_owner] = mem_rdata;
            m_busy = 0; m_owner = 3;
        end
        chk("grant", 32'(grant), 32'(m_owner));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("mem_req", 32'(mem_req), 32'(m_busy));
        if (m_busy != 0) begin
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            chk("mem_be", 32'(mem_be), 32'(m_be));
        end
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("p%0d_ack", p), 32'(d_ack[p]), 32'(m_ack[p]));
            chk($sformatf("p%0d_rdata", p), 32'(d_rdata[p]), 32'(m_rdata[p]));
        end
        if (auto_mode) begin
            for (int p = 0; p < 3; p++) begin
                if (m_ack[p] && remaining[p] > 0) remaining[p]--;
                if (remaining[p] > 0) begin
                    if (m_ack[p] || (!r_req[p] && (!gap_mode || $urandom_range(0, 3) != 0))) begin
                        new_params(p);
                        r_req[p] = 1'b1;
                    end
                end else begin
                    r_req[p] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input string tag, input int budget);
        for (int c = 0; c < budget && (rem_sum() > 0 || m_busy != 0); c++) tick();
        chk(tag, 32'(rem_sum() + m_busy), 32'd0);
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, "_len"}, 32'(grant_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++)
            chk($sformatf("%s_%0d", tag, i), 32'(grant_log[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int n_ack, ack_at, gap;
        for (int p = 0; p < 3; p++) begin
            r_addr[p] = '0; r_wdata[p] = '0; r_be[p] = '0; remaining[p] = 0; m_rdata[p] = '0;
        end

        // reset values
        repeat (3) tick();
        chk("rst_grant", 32'(grant), 32'd3);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        // single read on port 1, 3-cycle controller latency
        fix_lat = 3; fix_data_en = 1'b1; fix_rdata = 16'hBEEF;
        r_we[1] = 1'b0; r_addr[1] = 25'h000100; r_req[1] = 1'b1;
        tick();
        chk("rd_grant", 32'(grant), 32'd1);
        chk("rd_addr", 32'(mem_addr), 32'h100);
        n_ack = 0; ack_at = -1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (d_ack[1]) begin
                n_ack++;
                if (ack_at < 0) ack_at = c + 1;
                r_req[1] = 1'b0;
            end
        end
        chk("rd_ack_count", 32'(n_ack), 32'd1);
        chk("rd_ack_latency", 32'(ack_at), 32'd3);
        chk("rd_rdata", 32'(d_rdata[1]), 32'hBEEF);
        chk("rd_grant_idle", 32'(grant), 32'd3);

        // priority: all three request together
        fix_data_en = 1'b0; rand_lat = 1'b1; auto_mode = 1'b1;
        grant_log.delete();
        remaining[0] = 3; remaining[1] = 1; remaining[2] = 1;
        drain("prio_drain", 200);
        exp_q = {0, 0, 0, 1, 2};
        cmp_log("prio_order");

        // starvation: ports 1 and 2 both continuous
        grant_log.delete();
        remaining[0] = 0; remaining[1] = 10; remaining[2] = 2;
        drain("starve_drain", 400);
        exp_q.delete();
        for (int i = 0; i < STARVE_MAX; i++) exp_q.push_back(1);
        exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(2);
        cmp_log("starve_order");
        auto_mode = 1'b0;

        // loader burst on port 0, new request presented in each ack cycle
        for (int i = 0; i < 4; i++) begin
            r_we[0] = 1'b1; r_addr[0] = ADDR_W'(2 * i);
            r_wdata[0] = DATA_W'(16'h1111 * (i + 1)); r_be[0] = 2'b11; r_req[0] = 1'b1;
            gap = 0;
            for (int c = 0; c < 10; c++) begin
                tick(); gap++;
                if (m_busy != 0) break;
            end
            chk("burst_addr", 32'(mem_addr), 32'(2 * i));
            chk("burst_wdata", 32'(mem_wdata), 32'h1111 * (i + 1));
            chk("burst_we_be", 32'({mem_we, mem_be}), 32'h7);
            if (i > 0) chk("burst_gap", 32'(gap), 32'd1);
            for (int c = 0; c < 10; c++) begin
                tick();
                if (m_ack[0]) break;
            end
            chk("burst_ack", 32'(d_ack[0]), 32'd1);
            if (i == 3) r_req[0] = 1'b0;
        end

        // withdrawal one cycle after grant
        rand_lat = 1'b0; fix_lat = 3;
        r_we[1] = 1'b0; r_addr[1] = 25'h0ABCDE; r_req[1] = 1'b1;
        tick();
        chk("wd_grant", 32'(grant), 32'd1);
        tick();
        r_req[1] = 1'b0;
        n_ack = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (d_ack[1]) n_ack++;
        end
        chk("wd_ack_count", 32'(n_ack), 32'd1);

        // spurious mem_ack while idle
        inject_req++;
        n_ack = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_ack += int'(d_ack[0]) + int'(d_ack[1]) + int'(d_ack[2]);
        end
        chk("spur_acks", 32'(n_ack), 32'd0);
        chk("spur_busy", 32'(busy), 32'd0);

        // reset mid-transaction with port 1 granted
        fix_lat = 6;
        r_we[1] = 1'b0; r_addr[1] = 25'h000200; r_req[1] = 1'b1;
        tick(); tick();
        chk("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_mem_req", 32'(mem_req), 32'd0);
        chk("mid_grant", 32'(grant), 32'd3);
        chk("mid_busy", 32'(busy), 32'd0);
        model_reset();
        r_req[1] = 1'b0;
        tick(); tick();
        reset = 1'b0;
        fix_lat = 2; fix_data_en = 1'b1; fix_rdata = 16'h5A5A;
        r_we[2] = 1'b0; r_addr[2] = 25'h1ABCDE; r_req[2] = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (d_ack[2]) begin
                n_ack++;
                r_req[2] = 1'b0;
            end
        end
        chk("post_rst_ack", 32'(n_ack), 32'd1);
        chk("post_rst_rdata", 32'(d_rdata[2]), 32'h5A5A);
        chk("post_rst_p1_ack", 32'(d_ack[1]), 32'd0);

        // randomized traffic with idle gaps and random latency
        fix_data_en = 1'b0; rand_lat = 1'b1; auto_mode = 1'b1; gap_mode = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < 3; p++) remaining[p] = int'($urandom_range(0, 12));
            drain("rand_drain", 1500);
        end
        auto_mode = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_port_arb.md
Name: sdram_port_arb

Overview:
- Three-requester arbiter sharing the single SDRAM controller command port.
- Requesters: port 0 is the ioctl ROM/RAM loader, port 1 is the CPU bus, port 2 is the auxiliary port (backup RAM / debug).
- Sits between the requesters and the SDRAM controller, which is clocked on the same domain.
- Serialises one transaction at a time and applies fixed priority with a starvation guard for port 2.

Parameters:
- ADDR_W, 25, byte address width, matching ioctl_addr.
- DATA_W, 16, data width of one SDRAM word.
- STARVE_MAX, 8, number of consecutive lost arbitrations after which pending port 2 is forced to win.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pN_req  in  1  (N=0..2) request, level; held until pN_ack.
- pN_we  in  1  1=write, 0=read.
- pN_addr  in  ADDR_W  byte address; bit 0 ignored.
- pN_wdata  in  DATA_W  write data.
- pN_be  in  2  byte enables; writes only.
- pN_ack  out  1  one-cycle completion pulse.
- pN_rdata  out  DATA_W  read data; valid in the pN_ack cycle.
- mem_req  out  1  command to controller, held until mem_ack.
- mem_we  out  1  latched write flag.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_be  out  2  latched byte enables.
- mem_ack  in  1  one-cycle completion pulse from controller.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- grant  out  2  port currently owning mem_* (3 = none).
- busy  out  1  a transaction is outstanding.

Behaviour:
- Reset values: all outputs 0 except grant=3; state IDLE; starvation counter 0.
- States: IDLE, BUSY.
- IDLE:
  - If any pN_req is high, select the winner and latch its we/addr/wdata/be into mem_*.
  - Set mem_req=1, busy=1, grant=winner; go to BUSY.
  - The latch happens on the edge after the request is seen, so there is 1 cycle of arbitration latency.
- Winner selection:
  - If p2_req is pending and starve_cnt == STARVE_MAX, port 2 wins.
  - Otherwise fixed priority: port 0, then port 1, then port 2.
- Starvation counter:
  - At each grant to port 0 or 1 while p2_req is high, increment, saturating at STARVE_MAX.
  - Clear on a grant to port 2, or on any grant while p2_req is low.
- BUSY:
  - mem_* stay stable.
  - Requester inputs are ignored; changing pN_addr/pN_wdata mid-transaction has no effect.
  - On mem_ack: in the same edge, drop mem_req, pulse pN_ack for the granted port, register pN_rdata <= mem_rdata (reads and writes alike), set grant=3, busy=0, and go to IDLE.
- Turnaround:
  - Minimum 1 IDLE cycle between transactions.
  - The requester sees pN_ack on the cycle after mem_ack.
  - The requester must drop pN_req in its ack cycle or present a new request. A req still high in the first IDLE cycle after ack is treated as a new request.
- pN_rdata holds its value until the next ack to that port.
- Withdrawal: if pN_req drops while that port is granted, the transaction still completes and pN_ack still pulses.
- mem_ack while IDLE: ignored, no pN_ack generated.
- mem_ack arriving in the first BUSY cycle is legal and completes normally.
- Address bit 0 is passed through unchanged; the controller ignores it.
- Reset asserted mid-transaction:
  - Outputs return immediately to reset values; the outstanding transaction is abandoned with no ack.
  - The controller shares the reset, so no stale mem_ack is expected after reset.

Test Plan:
- Single read: p1_req, we=0, addr=0x000100; controller acks 3 cycles after mem_req with rdata=0xBEEF -> mem_addr=0x000100 latched 1 cycle after req, p1_ack pulses exactly once with p1_rdata=0xBEEF, grant returns to 3.
- Priority: p0, p1 and p2 all request on the same cycle, each re-requesting after its ack -> grant order 0,0,... while p0 is active. After p0 stops: 1, then 2.
- Starvation: p1 requests continuously, p2 requests continuously, STARVE_MAX=8 -> exactly 8 p1 grants, then one p2 grant, then the counter restarts.
- Loader burst: p0 writes 4 words at addr 0x0,0x2,0x4,0x6 with data 0x1111..0x4444 and be=3 -> mem_* sequence matches in order, with one IDLE cycle between each.
- Withdrawal and spurious ack: p1 drops req 1 cycle after grant -> p1_ack still pulses. A mem_ack injected in IDLE -> no pN_ack, state stays IDLE.
- Reset mid-operation: assert reset while busy=1 with p1 granted -> mem_req=0, grant=3, busy=0 immediately. After release, a new p2 request is served normally.
